pio_blink_ctrl: RTL
===================

PIO_BLINK_CTRL -- requirements
Module: pio_blink_ctrl

Interface
REQ-001 SHALL have clk, input, 1, system clock; all state on rising edge.
REQ-002 SHALL have reset_n, input, 1, reset, asynchronous, active-low.
REQ-003 SHALL have s_address, input, 2, Avalon-MM slave register select.
REQ-004 SHALL have s_chipselect, input, 1, slave select.
REQ-005 SHALL have s_write_n, input, 1, slave write strobe, active-low.
REQ-006 SHALL have s_writedata, input, 32, slave write data.
REQ-007 SHALL have s_readdata, output, 32, slave read data; combinational from s_address; zero wait states.
REQ-008 SHALL have m_address, output, 2, PIO master address; constant 0.
REQ-009 SHALL have m_chipselect, output, 1, PIO master select.
REQ-010 SHALL have m_write_n, output, 1, PIO master write strobe, active-low.
REQ-011 SHALL have m_writedata, output, 32, PIO write data: {31'b0, level}.
REQ-012 SHALL have irq, output, 1, done interrupt; present only with PIO_BLINK_CTRL_IRQ_EN.

Function
REQ-013 SHALL decode slave writes as s_chipselect=1 and s_write_n=0.
REQ-014 SHALL map registers: 0 CTRL (W: bit0 START, bit1 CONT, bit2 STOP; R: {29'b0, done, cont, busy}); 1 PERIOD (24-bit R/W); 2 COUNT (16-bit; W sets toggle count; R returns remaining); 3 LEVEL (R: {31'b0, level}; W bit0: force level).
REQ-015 SHALL implement FSM IDLE, WAIT, WRITE; busy=1 in WAIT or WRITE.
REQ-016 IDLE + START: load remaining=COUNT, timer=max(PERIOD,1)-1, latch cont, clear done, enter WAIT.
REQ-017 START with COUNT=0 and CONT=0: remain IDLE, set done, issue no master write.
REQ-018 WAIT: decrement timer each cycle; timer=0 -> WRITE next edge.
REQ-019 WRITE: exactly one cycle with m_chipselect=1, m_write_n=0, m_writedata bit0=~level; level toggles at the closing edge.
REQ-020 WRITE exit: if cont=1 or remaining>1, decrement remaining (cont=1: no decrement), reload timer, enter WAIT; else remaining=0, done=1, enter IDLE.
REQ-021 Interval between consecutive master writes SHALL be max(PERIOD,1)+1 cycles; first write begins max(PERIOD,1) edges after the edge sampling START.
REQ-022 STOP in WAIT or WRITE: enter IDLE at next edge; in WRITE the strobe SHALL still complete that cycle but level/remaining unchanged after; done not set.
REQ-023 START and STOP in same write: STOP wins; START while busy ignored.
REQ-024 LEVEL write in IDLE: level<=bit0 and one master write cycle of that value next cycle; LEVEL write while busy ignored.
REQ-025 PERIOD/COUNT writes while busy SHALL update registers but not the running timer/remaining.
REQ-026 Outside WRITE/forced write: m_chipselect=0, m_write_n=1.
REQ-027 done SHALL be sticky; cleared only by START or by CTRL write with bit3=1.

Reset
REQ-028 reset_n=0 SHALL asynchronously force: state IDLE, PERIOD=0, COUNT=0, remaining=0, timer=0, level=0, cont=0, done=0, m_chipselect=0, m_write_n=1, irq=0.
REQ-029 Reset mid-sequence SHALL abort with no further master writes.

Configuration
REQ-030 With PIO_BLINK_CTRL_IRQ_EN defined: irq port present, irq=done AND ie, ie=CTRL bit4 (R/W, reset 0), readable at CTRL bit4.
REQ-031 Without PIO_BLINK_CTRL_IRQ_EN: no irq port, CTRL bit4 ignored, reads 0.

Verification
REQ-032 PERIOD=3, COUNT=4, START -> 4 master writes, values 1,0,1,0, first 3 edges after START, spaced 4 cycles; then done=1, busy=0, level=0.
REQ-033 PERIOD=0, COUNT=2, START -> writes spaced 2 cycles (PERIOD treated as 1); COUNT reads 0 at end.
REQ-034 CONT=1, PERIOD=5, START, STOP after 3 writes -> no 4th write, busy=0, done=0, level=1.
REQ-035 COUNT=0, START -> zero master writes, done=1 next cycle; LEVEL write 1 in IDLE -> one write of 1, level reads 1.
REQ-036 reset_n low during WAIT of COUNT=10 run -> all outputs at reset values immediately, no writes after release.
REQ-037 With PIO_BLINK_CTRL_IRQ_EN, ie=1, COUNT=1 -> irq rises with done; CTRL bit3 write -> irq=0.

Source files
------------

// File: rtl/pio_blink_ctrl.sv
// -----------------------------------------------------------------------------
// pio_blink_ctrl
//
// Purpose:
//   Avalon-MM slave-controlled blinker. It drives a PIO peripheral through a
//   small Avalon-MM master port. Software sets a PERIOD and a toggle COUNT and
//   then issues START. The block then writes an alternating level to the PIO,
//   one write every max(PERIOD,1)+1 cycles. It stops after COUNT writes. In
//   continuous mode (CONT) it runs until STOP. While the block is idle,
//   software may also force the PIO level directly.
//
// Register map (s_address):
//   0 CTRL   W: bit0 START, bit1 CONT, bit2 STOP, bit3 clear done, bit4 ie
//            R: {27'b0, ie, 1'b0, done, cont, busy}   (ie reads 0 w/o IRQ)
//   1 PERIOD 24-bit R/W
//   2 COUNT  W: toggle count (16-bit); R: remaining toggles
//   3 LEVEL  W bit0: force level (idle only); R: {31'b0, level}
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   s_address/s_chipselect/s_write_n/s_writedata/s_readdata
//                           Avalon-MM slave (zero wait states, comb. read)
//   m_address/m_chipselect/m_write_n/m_writedata
//                           Avalon-MM master towards the PIO data register
//   irq                     done interrupt (only with PIO_BLINK_CTRL_IRQ_EN)
//
// Configuration macro:
//   PIO_BLINK_CTRL_IRQ_EN   adds the irq port and the CTRL bit4 enable (ie)
// -----------------------------------------------------------------------------
module pio_blink_ctrl (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  s_address,
   input  logic        s_chipselect,
   input  logic        s_write_n,
   input  logic [31:0] s_writedata,
   output logic [31:0] s_readdata,
   output logic [1:0]  m_address,
   output logic        m_chipselect,
   output logic        m_write_n,
   output logic [31:0] m_writedata
`ifdef PIO_BLINK_CTRL_IRQ_EN
   ,
   output logic        irq
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_WRITE = 2'd2
   } state_t;

   state_t      state_r;
   state_t      state_next_s;

   logic [23:0] period_r;
   logic [15:0] count_r;
   logic [15:0] remaining_r;
   logic [23:0] timer_r;
   logic        level_r;
   logic        cont_r;
   logic        done_r;
   logic        force_wr_r;
   logic        ie_r;

   logic        wr_s;
   logic        ctrl_wr_s;
   logic        start_s;
   logic        stop_s;
   logic        launch_s;
   logic        more_s;
   logic [23:0] reload_s;
   logic        master_wr_s;
   logic        unused_s;

   // Slave write decode. STOP overrides START in the same CTRL write.
   assign wr_s      = s_chipselect & ~s_write_n;
   assign ctrl_wr_s = wr_s & (s_address == 2'd0);
   assign stop_s    = ctrl_wr_s & s_writedata[2];
   assign start_s   = ctrl_wr_s & s_writedata[0] & ~s_writedata[2];

   // A START from IDLE only runs when there is work: a count or CONT mode.
   assign launch_s  = start_s & ((count_r != 16'd0) | s_writedata[1]);

   // Another WAIT period follows this WRITE when running continuously or
   // when more toggles remain.
   assign more_s    = cont_r | (remaining_r > 16'd1);

   // A PERIOD of 0 behaves like 1, so the timer reload never underflows.
   assign reload_s  = (period_r == 24'd0) ? 24'd0 : (period_r - 24'd1);

`ifdef PIO_BLINK_CTRL_IRQ_EN
   assign irq      = done_r & ie_r;
   assign unused_s = ^{s_writedata[31:5]};
`else
   assign unused_s = ^{s_writedata[31:4], ie_r};
`endif

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (launch_s) begin
               state_next_s = ST_WAIT;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (stop_s) begin
               state_next_s = ST_IDLE;
            end else if (timer_r == 24'd0) begin
               state_next_s = ST_WRITE;
            end else begin
               state_next_s = ST_WAIT;
            end
         end
         ST_WRITE: begin
            if (stop_s) begin
               state_next_s = ST_IDLE;
            end else if (more_s) begin
               state_next_s = ST_WAIT;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // Master port outputs. A forced level write reuses the strobe for one cycle
   // and carries the new level. A blink write carries the inverted current
   // level, which becomes the level at the closing edge.
   always_comb begin
      master_wr_s  = 1'b0;
      m_writedata  = 32'd0;
      if (state_r == ST_WRITE) begin
         master_wr_s = 1'b1;
         m_writedata = {31'd0, ~level_r};
      end else if (force_wr_r) begin
         master_wr_s = 1'b1;
         m_writedata = {31'd0, level_r};
      end else begin
         master_wr_s = 1'b0;
         m_writedata = {31'd0, level_r};
      end
   end

   assign m_address    = 2'd0;
   assign m_chipselect = master_wr_s;
   assign m_write_n    = ~master_wr_s;

   // Configuration registers, written at any time.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         period_r <= 24'd0;
         count_r  <= 16'd0;
         ie_r     <= 1'b0;
      end else begin
         if (wr_s && (s_address == 2'd1)) begin
            period_r <= s_writedata[23:0];
         end
         if (wr_s && (s_address == 2'd2)) begin
            count_r <= s_writedata[15:0];
         end
`ifdef PIO_BLINK_CTRL_IRQ_EN
         if (ctrl_wr_s) begin
            ie_r <= s_writedata[4];
         end
`endif
      end
   end

   // Sequencing datapath: timer, remaining count, level, cont latch, forced write.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         timer_r     <= 24'd0;
         remaining_r <= 16'd0;
         level_r     <= 1'b0;
         cont_r      <= 1'b0;
         force_wr_r  <= 1'b0;
      end else begin
         force_wr_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start_s) begin
                  remaining_r <= count_r;
                  timer_r     <= reload_s;
                  cont_r      <= s_writedata[1];
               end else if (wr_s && (s_address == 2'd3)) begin
                  level_r    <= s_writedata[0];
                  force_wr_r <= 1'b1;
               end
            end
            ST_WAIT: begin
               if (!stop_s && (timer_r != 24'd0)) begin
                  timer_r <= timer_r - 24'd1;
               end
            end
            ST_WRITE: begin
               // On STOP the strobe has already gone out this cycle. Level
               // and remaining keep their values.
               if (!stop_s) begin
                  level_r <= ~level_r;
                  if (more_s) begin
                     timer_r <= reload_s;
                     if (!cont_r) begin
                        remaining_r <= remaining_r - 16'd1;
                     end
                  end else begin
                     remaining_r <= 16'd0;
                  end
               end
            end
            default: begin
               timer_r <= 24'd0;
            end
         endcase
      end
   end

   // Sticky done flag. It sets on normal completion or on an empty START.
   // Only START or a CTRL bit3 write clears it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         done_r <= 1'b0;
      end else begin
         if ((state_r == ST_IDLE) && start_s) begin
            done_r <= ~launch_s;
         end else if ((state_r == ST_WRITE) && !stop_s && !more_s) begin
            done_r <= 1'b1;
         end else if (ctrl_wr_s && s_writedata[3]) begin
            done_r <= 1'b0;
         end
      end
   end

   // Combinational read mux: zero wait states.
   always_comb begin
      s_readdata = 32'd0;
      case (s_address)
         2'd0: begin
`ifdef PIO_BLINK_CTRL_IRQ_EN
            s_readdata = {27'd0, ie_r, 1'b0, done_r, cont_r,
                          (state_r != ST_IDLE)};
`else
            s_readdata = {29'd0, done_r, cont_r, (state_r != ST_IDLE)};
`endif
         end
         2'd1:    s_readdata = {8'd0, period_r};
         2'd2:    s_readdata = {16'd0, remaining_r};
         2'd3:    s_readdata = {31'd0, level_r};
         default: s_readdata = 32'd0;
      endcase
   end

endmodule
